// File: rtl/block_distribution_am_insert_if.sv
// Block-stream bus between the scrambler-side source and the lane distributor.
// The source drives i_valid/i_data; the distributor returns full lane rows on o_*.
interface block_distribution_am_insert_if #(
   parameter int LEN_CODED_BLOCK = 66,
   parameter int NB_LANES        = 20
);
   logic                                i_valid;
   logic [LEN_CODED_BLOCK-1:0]          i_data;
   logic [NB_LANES*LEN_CODED_BLOCK-1:0] o_data;
   logic                                o_valid;
   logic                                o_am_flag;

   modport master (
      output i_valid,
      output i_data,
      input  o_data,
      input  o_valid,
      input  o_am_flag
   );

   modport slave (
      input  i_valid,
      input  i_data,
      output o_data,
      output o_valid,
      output o_am_flag
   );
endinterface

// File: rtl/block_distribution_am_insert.sv
// Round-robin block distribution over NB_LANES with an AM row ahead of every AM_PERIOD data rows.
// Row visible one cycle after its last block; no backpressure, i_enable low freezes everything.
module block_distribution_am_insert #(
   parameter int LEN_CODED_BLOCK = 66,
   parameter int NB_LANES        = 20,
   parameter int AM_PERIOD       = 16383,
   parameter int NB_ROW_CNT      = 14
) (
   input  logic                                i_clock,
   input  logic                                i_reset,
   input  logic                                i_enable,
   input  logic [NB_LANES*LEN_CODED_BLOCK-1:0] i_am_data,
   output logic                                o_am_pending,
   block_distribution_am_insert_if.slave       bus
);
   localparam int LANE_W = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;

   typedef enum logic {
      S_AM   = 1'b0,
      S_DATA = 1'b1
   } state_t;

   state_t                              r_state;
   logic [LANE_W-1:0]                   r_lane_idx;
   logic [NB_ROW_CNT-1:0]               r_row_cnt;
   logic [LEN_CODED_BLOCK-1:0]          r_buf [NB_LANES-1];
   logic [NB_LANES*LEN_CODED_BLOCK-1:0] r_data;
   logic                                r_valid;
   logic                                r_am_flag;

   logic                                w_capture;
   logic                                w_last;
   logic                                w_period_end;
   logic [NB_LANES*LEN_CODED_BLOCK-1:0] w_row;

   assign w_capture    = i_enable && bus.i_valid;
   assign w_last       = w_capture && (r_lane_idx == LANE_W'(NB_LANES - 1));
   assign w_period_end = (r_row_cnt == NB_ROW_CNT'(AM_PERIOD - 1));

   // The final lane is taken straight from i_data so the row leaves on the same edge it completes.
   always_comb begin
      w_row = '0;
      for (int k = 0; k < NB_LANES - 1; k++) begin
         w_row[k*LEN_CODED_BLOCK +: LEN_CODED_BLOCK] = r_buf[k];
      end
      w_row[(NB_LANES-1)*LEN_CODED_BLOCK +: LEN_CODED_BLOCK] = bus.i_data;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= S_AM;
         r_lane_idx <= '0;
         r_row_cnt  <= '0;
         for (int k = 0; k < NB_LANES - 1; k++) begin
            r_buf[k] <= '0;
         end
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_am_flag <= 1'b0;
      end else if (i_enable) begin
         r_valid   <= 1'b0;
         r_am_flag <= 1'b0;

         if (w_capture) begin
            if (w_last) begin
               r_lane_idx <= '0;
            end else begin
               r_lane_idx        <= r_lane_idx + LANE_W'(1);
               r_buf[r_lane_idx] <= bus.i_data;
            end
         end

         // A row completion can never coincide with S_AM: the AM slot always sits at lane 0.
         if (w_last) begin
            r_data  <= w_row;
            r_valid <= 1'b1;
            if (w_period_end) begin
               r_row_cnt <= '0;
               r_state   <= S_AM;
            end else begin
               r_row_cnt <= r_row_cnt + NB_ROW_CNT'(1);
            end
         end else if (r_state == S_AM) begin
            r_data    <= i_am_data;
            r_valid   <= 1'b1;
            r_am_flag <= 1'b1;
            r_state   <= S_DATA;
         end
      end else begin
         r_valid   <= 1'b0;
         r_am_flag <= 1'b0;
      end
   end

   assign bus.o_data    = r_data;
   assign bus.o_valid   = r_valid;
   assign bus.o_am_flag = r_am_flag;
   assign o_am_pending  = (r_state == S_AM);

   a_no_row_collision: assert property (
      @(posedge i_clock) disable iff (i_reset)
      !(w_last && (r_state == S_AM))
   );

   a_lane_in_range: assert property (
      @(posedge i_clock) disable iff (i_reset)
      (r_lane_idx <= LANE_W'(NB_LANES - 1))
   );
endmodule
